// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB master arbiter.
//   state_t        : transfer sequencer states (IDLE -> SETUP -> ACCESS)
//   RESP_OKAY/ERR  : values driven on rsp_err
//   tmo_cnt_width  : width of the bus-timeout counter for a given TIMEOUT
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_t;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  // The counter must be able to hold TIMEOUT itself. TIMEOUT=0 disables the
  // watchdog, but a 1-bit counter is still kept so the logic stays uniform.
  function automatic int tmo_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_grant : index of the previously granted requester
//   grant      : one-hot winner (all zero when no request)
//   idx        : binary index of the winner (0 when no request)
// The search starts at last_grant+1 and wraps modulo N, so the most recently
// served requester has the lowest priority.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(last_grant) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters.
//   HCLK, HRESETn      : clock, synchronous active-low reset
//   req_valid/write/addr/wdata : per-requester request (packed, requester i
//                        at [i*W +: W]); held until req_ready
//   req_ready          : one-hot accept pulse (combinational)
//   rsp_valid          : one-hot completion pulse (registered)
//   rsp_rdata, rsp_err : completion data / error, valid with rsp_valid
//   PSEL..PSLVERR      : APB master port
// Round-robin arbitration happens in IDLE and in the ACCESS completion cycle,
// so back-to-back transfers run at one per two cycles with PSEL held high.
// A watchdog completes an ACCESS with an error after TIMEOUT wait cycles.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_rdata,
  output logic                            rsp_err,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic                            PWRITE,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  input  logic [DATA_WIDTH-1:0]           PRDATA,
  input  logic                            PREADY,
  input  logic                            PSLVERR
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = tmo_cnt_width(TIMEOUT);
  // Counter value during the last permitted wait cycle: the watchdog fires
  // when this cycle would push the count to TIMEOUT.
  localparam logic [CW-1:0] TMO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t                state_reg, state_next;
  logic [IW-1:0]         last_grant_reg;
  logic [IW-1:0]         grant_idx_reg;
  logic [CW-1:0]         cnt_reg;
  logic [NUM_REQ-1:0]    win_grant;
  logic [IW-1:0]         win_idx;
  logic                  any_req;
  logic                  timeout_hit;
  logic                  complete;
  logic                  accept;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_reg),
    .grant      (win_grant),
    .idx        (win_idx)
  );

  assign any_req     = |req_valid;
  assign timeout_hit = (TIMEOUT > 0) && (state_reg == ST_ACCESS) && !PREADY &&
                       (cnt_reg == TMO_LAST);
  assign complete    = (state_reg == ST_ACCESS) && (PREADY || timeout_hit);
  // Gated by reset so no accept pulse is shown while the edge will discard it.
  assign accept      = HRESETn && any_req &&
                       ((state_reg == ST_IDLE) || complete);
  assign req_ready   = accept ? win_grant : '0;

  assign PSEL    = (state_reg != ST_IDLE);
  assign PENABLE = (state_reg == ST_ACCESS);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (any_req) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (complete) state_next = any_req ? ST_SETUP : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      last_grant_reg <= IW'(NUM_REQ - 1);
      grant_idx_reg  <= '0;
      cnt_reg        <= '0;
      PADDR          <= '0;
      PWRITE         <= 1'b0;
      PWDATA         <= '0;
      rsp_valid      <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= RESP_OKAY;
    end else begin
      rsp_valid <= '0;

      if (accept) begin
        PADDR          <= addr_arr[win_idx];
        PWRITE         <= req_write[win_idx];
        PWDATA         <= wdata_arr[win_idx];
        grant_idx_reg  <= win_idx;
        last_grant_reg <= win_idx;
      end

      if (state_reg == ST_SETUP) begin
        cnt_reg <= '0;
      end else if ((state_reg == ST_ACCESS) && !complete && (cnt_reg != '1)) begin
        cnt_reg <= cnt_reg + CW'(1);
      end

      // PWRITE still describes the completing transfer here; a same-cycle
      // accept only updates it at this edge.
      if (complete) begin
        rsp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_reg;
        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
        rsp_err   <= PREADY ? PSLVERR : RESP_ERR;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter (NUM_REQ=2, TIMEOUT=4).
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
module tb_apb_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic [AW-1:0]     PADDR;
  logic              PWRITE;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  // Slave model: read data is a fixed word or derived from the address.
  logic              use_fixed;
  logic [DW-1:0]     fixed_data;
  assign PRDATA = use_fixed ? fixed_data : (PADDR ^ KEY);

  always #5 HCLK = ~HCLK;

  apb_master_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_last = 1;

  function automatic int rr_pick(input logic [1:0] v, input int last);
    for (int k = 1; k <= 2; k++) begin
      int c = (last + k) % 2;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge HCLK);
      #1;
      if (rsp_valid != 0) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    exp_t e;
    HRESETn = 1'b0; req_valid = 2'b11; req_write = '0; req_addr = '0;
    req_wdata = '0; PREADY = 1'b0; PSLVERR = 1'b0; use_fixed = 1'b0;
    fixed_data = '0;
    repeat (3) @(negedge HCLK);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE} !== 9'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0", {req_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE});
    end
    checks++;
    if ({PADDR, PWDATA, rsp_rdata} !== 96'b0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", {PADDR, PWDATA, rsp_rdata});
    end
    @(negedge HCLK);
    req_valid = 2'b00; HRESETn = 1'b1;
    #1;
    checks++;
    if (PSEL !== 1'b0) begin
      failures++;
      $display("FAIL idle_psel: got %b expected 0", PSEL);
    end
    exp_last = 1;
    e.idx = 0; // keep e used
    $display("reset done");
  endtask

  task automatic test_single_read();
    exp_t e;
    bit   got;
    @(negedge HCLK);
    use_fixed = 1'b1; fixed_data = 32'hDEADBEEF; PREADY = 1'b1;
    req_write = 2'b00; req_addr[31:0] = 32'h40; req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL single_grant: got %b expected 01", req_ready);
    end
    exp_last = 0;
    sb_q.push_back('{0, 32'hDEADBEEF, 1'b0});
    @(negedge HCLK);
    req_valid = 2'b00;
    #1;
    checks++;
    if ({PSEL, PENABLE, PADDR} !== {2'b10, 32'h40}) begin
      failures++;
      $display("FAIL single_setup: got %b %b %h expected 1 0 00000040", PSEL, PENABLE, PADDR);
    end
    @(negedge HCLK);
    #1;
    checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 4'b1100) begin
      failures++;
      $display("FAIL single_access: got %b expected 1100", {PSEL, PENABLE, rsp_valid});
    end
    @(negedge HCLK);
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || sb_q.size() == 0) begin
      failures++;
      $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
        failures++;
        $display("FAIL single_rsp: got %h/%b expected %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    checks++;
    if (PSEL !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: got PSEL %b expected 0", PSEL);
    end
    use_fixed = 1'b0;
    $display("xfer single_read req0 addr=00000040 rdata=%h err=%b", rsp_rdata, rsp_err);
  endtask

  task automatic test_wait_write();
    exp_t e;
    @(negedge HCLK);
    PREADY = 1'b0; req_write = 2'b10; req_addr[63:32] = 32'h1000;
    req_wdata[63:32] = 32'hA5A5A5A5; req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL write_grant: got %b expected 10", req_ready);
    end
    exp_last = 1;
    sb_q.push_back('{1, 32'h0, 1'b0});
    @(negedge HCLK);
    req_valid = 2'b00;
    #1;
    checks++;
    if ({PSEL, PENABLE} !== 2'b10) begin
      failures++;
      $display("FAIL write_setup: got %b expected 10", {PSEL, PENABLE});
    end
    for (int w = 0; w < 3; w++) begin
      @(negedge HCLK);
      #1;
      checks++;
      if ({PENABLE, PWRITE, PADDR, PWDATA, rsp_valid} !== {2'b11, 32'h1000, 32'hA5A5A5A5, 2'b00}) begin
        failures++;
        $display("FAIL write_wait%0d: got %b %b %h %h %b expected 1 1 00001000 a5a5a5a5 00",
                 w, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid);
      end
    end
    @(negedge HCLK);
    PREADY = 1'b1;
    @(negedge HCLK);
    PREADY = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b10 || sb_q.size() == 0) begin
      failures++;
      $display("FAIL write_rsp_valid: got %b expected 10", rsp_valid);
    end else begin
      e = sb_q.pop_front();
      checks++;
      if ({rsp_rdata, rsp_err} !== {e.rdata, e.err}) begin
        failures++;
        $display("FAIL write_rsp: got %h/%b expected %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
    $display("xfer wait_write req1 addr=00001000 rdata=%h err=%b", rsp_rdata, rsp_err);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   g_cnt [2];
    int   rsps = 0;
    int   last_rsp_cyc = -1;
    int   g;
    bit   started = 1'b0;
    g_cnt[0] = 0; g_cnt[1] = 0;
    @(negedge HCLK);
    req_write = 2'b00; req_addr[31:0] = 32'h100; req_addr[63:32] = 32'h200;
    PREADY = 1'b1; PSLVERR = 1'b0; req_valid = 2'b11;
    for (int c = 0; c < 30 && rsps < 4; c++) begin
      if (c > 0) begin
        @(negedge HCLK);
        req_valid[0] = (g_cnt[0] < 2);
        req_valid[1] = (g_cnt[1] < 2);
      end
      #1;
      if (started && sb_q.size() > 0 && !(rsp_valid != 0 && sb_q.size() == 1)) begin
        checks++;
        if (PSEL !== 1'b1) begin
          failures++;
          $display("FAIL b2b_psel cyc%0d: got %b expected 1", c, PSEL);
        end
      end
      if (rsp_valid != 0) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL b2b_unexpected_rsp: got %b expected none", rsp_valid);
        end else begin
          e = sb_q.pop_front();
          checks++;
          if ({rsp_valid, rsp_rdata, rsp_err} !== {2'b01 << e.idx, e.rdata, e.err}) begin
            failures++;
            $display("FAIL b2b_rsp: got %b %h %b expected %b %h %b",
                     rsp_valid, rsp_rdata, rsp_err, 2'b01 << e.idx, e.rdata, e.err);
          end
          if (last_rsp_cyc >= 0) begin
            checks++;
            if (c - last_rsp_cyc != 2) begin
              failures++;
              $display("FAIL b2b_spacing: got %0d expected 2", c - last_rsp_cyc);
            end
          end
          last_rsp_cyc = c;
          rsps++;
          $display("xfer b2b req%0d rdata=%h err=%b", e.idx, rsp_rdata, rsp_err);
        end
      end
      if (req_ready != 0) begin
        g = rr_pick(req_valid, exp_last);
        checks++;
        if (g < 0 || req_ready !== (2'b01 << g)) begin
          failures++;
          $display("FAIL b2b_grant: got %b expected req%0d", req_ready, g);
        end
        if (g >= 0) begin
          exp_last = g;
          g_cnt[g]++;
          sb_q.push_back('{g, ((g == 0) ? 32'h100 : 32'h200) ^ KEY, 1'b0});
        end
        started = 1'b1;
      end
    end
    checks++;
    if (rsps != 4) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected 4", rsps);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_slverr();
    exp_t e;
    bit   got;
    for (int t = 0; t < 2; t++) begin
      @(negedge HCLK);
      req_write = 2'b00;
      if (t == 0) begin
        req_addr[31:0] = 32'h300; req_valid = 2'b01; PREADY = 1'b1; PSLVERR = 1'b1;
      end else begin
        req_addr[63:32] = 32'h304; req_valid = 2'b10; PREADY = 1'b0; PSLVERR = 1'b1;
      end
      #1;
      checks++;
      if (req_ready !== ((t == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL slverr_grant%0d: got %b expected req%0d", t, req_ready, t);
      end
      exp_last = t;
      sb_q.push_back('{t, ((t == 0) ? 32'h300 : 32'h304) ^ KEY, (t == 0)});
      @(negedge HCLK);
      req_valid = 2'b00;
      if (t == 1) begin
        @(negedge HCLK);            // first ACCESS cycle: wait state with PSLVERR high
        @(negedge HCLK);
        PREADY = 1'b1; PSLVERR = 1'b0;
      end
      #1;
      wait_rsp(got);
      checks++;
      if (!got || sb_q.size() == 0) begin
        failures++;
        $display("FAIL slverr_timeout%0d: got no response expected rsp_valid", t);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if ({rsp_valid, rsp_rdata, rsp_err} !== {2'b01 << e.idx, e.rdata, e.err}) begin
          failures++;
          $display("FAIL slverr_rsp%0d: got %b %h %b expected %b %h %b",
                   t, rsp_valid, rsp_rdata, rsp_err, 2'b01 << e.idx, e.rdata, e.err);
        end
        $display("xfer slverr req%0d rdata=%h err=%b", e.idx, rsp_rdata, rsp_err);
      end
    end
    PSLVERR = 1'b0;
  endtask

  task automatic test_timeout();
    exp_t e;
    int   acc = 0;
    bit   got = 1'b0;
    @(negedge HCLK);
    req_write = 2'b00; req_addr[31:0] = 32'h400; req_valid = 2'b01;
    PREADY = 1'b0; PSLVERR = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL tmo_grant: got %b expected 01", req_ready);
    end
    exp_last = 0;
    sb_q.push_back('{0, 32'h0, 1'b1});
    for (int n = 0; n < 20; n++) begin
      @(negedge HCLK);
      req_valid = 2'b00;
      #1;
      if (rsp_valid != 0) begin
        got = 1'b1;
        break;
      end
      if (PENABLE) acc++;
    end
    checks++;
    if (!got || acc != 4) begin
      failures++;
      $display("FAIL tmo_cycles: got %0d access cycles (rsp %b) expected 4", acc, got);
    end
    if (got && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err, PSEL} !== {2'b01, e.rdata, e.err, 1'b0}) begin
        failures++;
        $display("FAIL tmo_rsp: got %b %h %b psel %b expected 01 %h %b psel 0",
                 rsp_valid, rsp_rdata, rsp_err, PSEL, e.rdata, e.err);
      end
      $display("xfer timeout req0 rdata=%h err=%b", rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   got;
    @(negedge HCLK);
    req_write = 2'b00; req_addr[31:0] = 32'h500; req_valid = 2'b01; PREADY = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rst_mid_grant: got %b expected 01", req_ready);
    end
    @(negedge HCLK);
    req_valid = 2'b00;
    @(negedge HCLK);
    #1;
    checks++;
    if (PENABLE !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_access: got PENABLE %b expected 1", PENABLE);
    end
    @(negedge HCLK);
    HRESETn = 1'b0; PREADY = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(negedge HCLK);
      #1;
      checks++;
      if ({PSEL, PENABLE, rsp_valid} !== 4'b0000) begin
        failures++;
        $display("FAIL rst_mid_abort%0d: got %b expected 0000", n, {PSEL, PENABLE, rsp_valid});
      end
    end
    exp_last = 1;
    @(negedge HCLK);
    HRESETn = 1'b1; req_addr[31:0] = 32'h600; req_addr[63:32] = 32'h700;
    req_valid = 2'b11;
    #1;
    g_check: begin
      int g;
      g = rr_pick(req_valid, exp_last);
      checks++;
      if (req_ready !== (2'b01 << g)) begin
        failures++;
        $display("FAIL rst_mid_first_grant: got %b expected req%0d", req_ready, g);
      end
      exp_last = g;
      sb_q.push_back('{g, ((g == 0) ? 32'h600 : 32'h700) ^ KEY, 1'b0});
    end
    @(negedge HCLK);
    req_valid = 2'b00;
    #1;
    wait_rsp(got);
    checks++;
    if (!got || sb_q.size() == 0) begin
      failures++;
      $display("FAIL rst_mid_timeout: got no response expected rsp_valid");
    end else begin
      e = sb_q.pop_front();
      checks++;
      if ({rsp_valid, rsp_rdata, rsp_err} !== {2'b01 << e.idx, e.rdata, e.err}) begin
        failures++;
        $display("FAIL rst_mid_rsp: got %b %h %b expected %b %h %b",
                 rsp_valid, rsp_rdata, rsp_err, 2'b01 << e.idx, e.rdata, e.err);
      end
      $display("xfer after_reset req%0d rdata=%h err=%b", e.idx, rsp_rdata, rsp_err);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL rst_mid_leftover: got %0d pending expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_wait_write();
    test_back_to_back();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time exceeded expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Shares one APB master port between NUM_REQ on-chip requesters, e.g. the AHB-to-APB bridge and a DMA or debug port.
- Arbitration is round-robin.
- The block sequences APB SETUP/ACCESS phases, honours PREADY wait states and samples PSLVERR.
- A bus-timeout watchdog guarantees forward progress.
- Sits between the requester-side request/response interfaces and the APB peripheral decoder.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT, 16, max ACCESS cycles waiting for PREADY; 0 disables the watchdog

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, synchronous, active-low
req_valid  in  NUM_REQ  per-requester request pending
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed request addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  ADDR_WIDTH  APB address
PWRITE  out  1  APB direction
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset: synchronous, active-low, on posedge HCLK. Takes effect even mid-transfer: next state is IDLE, PSEL/PENABLE drop at that edge, and no rsp_valid is issued for the aborted transfer.
  - All outputs reset to 0.
  - last_grant resets to NUM_REQ-1, so requester 0 wins first.
  - Timeout counter resets to 0.
- States: IDLE, SETUP, ACCESS (enum in package).
- Requester contract: hold req_valid and its fields stable until req_ready. Dropping req_valid early is illegal and unchecked. One outstanding transfer per requester.
- Arbitration, combinational in IDLE and in an ACCESS completion cycle:
  - Winner is the first asserted req_valid searching from last_grant+1, wrapping modulo NUM_REQ.
  - req_ready[winner] is high that cycle.
  - At the edge: latch address, write and wdata into PADDR/PWRITE/PWDATA; latch grant index; update last_grant; go to SETUP.
- IDLE: PSEL=0, PENABLE=0. If no request, stay.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS. Timeout counter cleared.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=0: stay and increment the counter.
  - PREADY=1 (complete):
    - Register rsp_valid[grant]=1 for one cycle.
    - rsp_rdata = PRDATA for reads, 0 for writes.
    - rsp_err = PSLVERR.
    - If any req_valid is pending, arbitrate in this cycle and go directly to SETUP (PENABLE drops, PSEL stays high, back-to-back). Otherwise go to IDLE.
  - Timeout: when TIMEOUT>0 and the counter reaches TIMEOUT with PREADY still low, complete with rsp_err=1 and rsp_rdata=0, then proceed as a normal completion.
  - PSLVERR is ignored unless PREADY=1.
- PADDR/PWRITE/PWDATA hold their last values while idle.
- Latency, zero-wait read:
  - req_ready at cycle T.
  - SETUP at T+1.
  - ACCESS with PREADY at T+2.
  - rsp_valid at T+3.
  - Each PREADY wait state adds one cycle.
- Back-to-back throughput: one transfer per 2 cycles.
- Counter width: $clog2(TIMEOUT+1), minimum 1. The counter saturates and never wraps.

Decomposition:
- Package apb_arb_pkg holds:
  - state enum {ST_IDLE, ST_SETUP, ST_ACCESS}
  - OKAY/ERR response constants
  - function computing the timeout counter width
- Sub-module rr_arbiter (parameter N; inputs req[N] and last_grant; outputs one-hot grant and index) implements the round-robin pick. The FSM, APB datapath and watchdog remain in apb_master_arbiter.

Test Plan:
- Single read, req 0 at 0x40 with PRDATA=0xDEADBEEF, PREADY=1 -> req_ready[0] at T, PSEL at T+1, PENABLE at T+2, rsp_valid[0] with rdata 0xDEADBEEF and err=0 at T+3.
- Write from req 1 at 0x1000 with 0xA5A5A5A5, PREADY held low 3 ACCESS cycles -> PADDR/PWDATA stable across all 3 wait cycles; rsp_valid[1] one cycle after PREADY; rsp_rdata=0.
- Both requesters continuously valid, 4 transfers -> grants 0,1,0,1; PSEL stays high between transfers; rsp_valid spacing 2 cycles.
- PREADY=1 with PSLVERR=1 on a read -> rsp_err=1; the next transfer proceeds normally with err=0.
- TIMEOUT=4 and PREADY never asserted -> completion after 4 ACCESS cycles with rsp_err=1 and rsp_rdata=0; PSEL low next cycle if no request pending.
- HRESETn low during ACCESS -> PSEL/PENABLE 0 after the edge, no rsp_valid; after release, requester 0 wins first.
